// File: rtl/pll_div_pkg.sv
// Shared types and helpers for the PLL divider model.
// The HOLD state is only reachable when PLL_STDBY_EN is defined.
package pll_div_pkg;

  typedef enum logic [1:0] {
    StLocking = 2'd0,
    StLocked  = 2'd1,
    StHold    = 2'd2
  } pll_state_e;

  // Ratios of 0 or 1 are raised to this value
  localparam int unsigned DIV_MIN = 2;

  function automatic int unsigned lock_cnt_width(int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pll_div_chan.sv
// One divided-clock channel: wrapping counter, ratio clamp and duty compare.
// Outputs are registered; run is the lock state the top will hold after this edge.
module pll_div_chan
  import pll_div_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic [DIV_W-1:0] ratio,
  output logic             clk_out,
  output logic             clk_en
);

  logic [DIV_W-1:0] div_eff, half, cnt_nxt;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_en_q, clk_en_d;

  always_comb begin
    div_eff = (ratio < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : ratio;
    half    = div_eff >> 1;
    // First running cycle starts at 0 so all channels come up phase-aligned
    cnt_nxt = '0;
    if (active_q && (cnt_q != div_eff - 1'b1)) begin
      cnt_nxt = cnt_q + 1'b1;
    end
    cnt_d     = cnt_nxt;
    active_d  = 1'b1;
    clk_out_d = (cnt_nxt < half);
    clk_en_d  = (cnt_nxt == div_eff - 1'b1);
    if (clr || !run) begin
      cnt_d     = '0;
      active_d  = 1'b0;
      clk_out_d = 1'b0;
      clk_en_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      active_q  <= 1'b0;
      clk_out_q <= 1'b0;
      clk_en_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      clk_out_q <= clk_out_d;
      clk_en_q  <= clk_en_d;
    end
  end

  assign clk_out = clk_out_q;
  assign clk_en  = clk_en_q;

endmodule

// File: rtl/pll_div_model.sv
// PLL model: deterministic lock counter plus N_CH phase-aligned clock dividers.
// Define PLL_STDBY_EN to add the stdby input and the HOLD state.
module pll_div_model
  import pll_div_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned LOCK_CYCLES = 64,
  parameter int unsigned DIV_RST     = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [N_CH*DIV_W-1:0]                     div_cfg,
  input  logic                                      cfg_load,
`ifdef PLL_STDBY_EN
  input  logic                                      stdby,
`endif
  output logic                                      extlock,
  output logic [N_CH-1:0]                           clk_out,
  output logic [N_CH-1:0]                           clk_en,
  output logic [lock_cnt_width(LOCK_CYCLES)-1:0]    lock_cnt
);

  localparam int unsigned LCW = lock_cnt_width(LOCK_CYCLES);
  localparam logic [LCW-1:0] LockLast = LCW'(LOCK_CYCLES - 1);
  localparam logic [LCW-1:0] LockFull = LCW'(LOCK_CYCLES);

  pll_state_e       state_q, state_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic             extlock_q, extlock_d;
  logic [DIV_W-1:0] ratio_q [N_CH];
  logic [DIV_W-1:0] ratio_d [N_CH];
  logic             chan_clr;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    extlock_d  = extlock_q;
    ratio_d    = ratio_q;
    if (cfg_load) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        ratio_d[i] = div_cfg[i*DIV_W +: DIV_W];
      end
    end
`ifdef PLL_STDBY_EN
    if (stdby) begin
      state_d    = StHold;
      lock_cnt_d = '0;
      extlock_d  = 1'b0;
    end else
`endif
    if (cfg_load) begin
      state_d    = StLocking;
      lock_cnt_d = '0;
      extlock_d  = 1'b0;
    end else begin
      unique case (state_q)
        // Leaving HOLD counts this edge as the first of a fresh lock sequence
        StLocking, StHold: begin
          if (lock_cnt_q == LockLast) begin
            state_d    = StLocked;
            lock_cnt_d = LockFull;
            extlock_d  = 1'b1;
          end else begin
            state_d    = StLocking;
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
        StLocked: begin
          lock_cnt_d = LockFull;
          extlock_d  = 1'b1;
        end
        default: begin
          state_d    = StLocking;
          lock_cnt_d = '0;
          extlock_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLocking;
      lock_cnt_q <= '0;
      extlock_q  <= 1'b0;
      ratio_q    <= '{default: DIV_W'(DIV_RST)};
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      extlock_q  <= extlock_d;
      ratio_q    <= ratio_d;
    end
  end

`ifdef PLL_STDBY_EN
  assign chan_clr = cfg_load | stdby;
`else
  assign chan_clr = cfg_load;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    pll_div_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (extlock_d),
      .clr     (chan_clr),
      .ratio   (ratio_q[g]),
      .clk_out (clk_out[g]),
      .clk_en  (clk_en[g])
    );
  end

  assign extlock  = extlock_q;
  assign lock_cnt = lock_cnt_q;

endmodule

// File: tb/tb_pll_div_model.sv
// Scoreboard bench for pll_div_model: expected per-edge outputs are queued when
// each edge is driven and compared just after that edge.
module tb_pll_div_model;

  localparam int LOCK  = 64;
  localparam int NCH   = 2;
  localparam int DW    = 8;
  localparam int DRST  = 2;
  localparam int CW    = $clog2(LOCK + 1);

  typedef struct {
    logic          lock;
    logic [CW-1:0] cnt;
    logic [NCH-1:0] out;
    logic [NCH-1:0] en;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic [NCH*DW-1:0]  div_cfg;
  logic               cfg_load;
  logic               extlock;
  logic [NCH-1:0]     clk_out;
  logic [NCH-1:0]     clk_en;
  logic [CW-1:0]      lock_cnt;
`ifdef PLL_STDBY_EN
  logic               stdby;
`endif

  exp_t sb[$];
  int   n_total;
  int   n_bad;
  int   since;
  int   d [NCH];

  pll_div_model #(
    .N_CH        (NCH),
    .DIV_W       (DW),
    .LOCK_CYCLES (LOCK),
    .DIV_RST     (DRST)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_cfg  (div_cfg),
    .cfg_load (cfg_load),
`ifdef PLL_STDBY_EN
    .stdby    (stdby),
`endif
    .extlock  (extlock),
    .clk_out  (clk_out),
    .clk_en   (clk_en),
    .lock_cnt (lock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got=%0h expected=%0h (since=%0d)", tag, $time, got, exp, since);
    end
  endtask

  // Expected outputs n edges after reset release / cfg_load, from the documented waveform
  function automatic exp_t model(input int n);
    exp_t e;
    int   k;
    e.lock = 1'b0;
    e.cnt  = CW'(n);
    e.out  = '0;
    e.en   = '0;
    if (n >= LOCK) begin
      k      = n - LOCK;
      e.lock = 1'b1;
      e.cnt  = CW'(LOCK);
      for (int c = 0; c < NCH; c++) begin
        e.out[c] = ((k % d[c]) < (d[c] / 2));
        e.en[c]  = ((k % d[c]) == (d[c] - 1));
      end
    end
    return e;
  endfunction

  task automatic set_ratios(input logic [NCH*DW-1:0] cfg);
    int r;
    for (int c = 0; c < NCH; c++) begin
      r    = int'(cfg[c*DW +: DW]);
      d[c] = (r < 2) ? 2 : r;
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("extlock", 32'(extlock), 32'(e.lock));
      check_eq("lock_cnt", 32'(lock_cnt), 32'(e.cnt));
      check_eq("clk_out", 32'(clk_out), 32'(e.out));
      check_eq("clk_en", 32'(clk_en), 32'(e.en));
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      since++;
      sb.push_back(model(since));
      @(posedge clk);
      #1;
      compare_head();
    end
  endtask

  task automatic load(input logic [NCH*DW-1:0] cfg);
    div_cfg  = cfg;
    cfg_load = 1'b1;
    set_ratios(cfg);
    since = 0;
    sb.push_back(model(0));
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    compare_head();
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    since    = 0;
    rst_n    = 1'b0;
    cfg_load = 1'b0;
    div_cfg  = '0;
`ifdef PLL_STDBY_EN
    stdby    = 1'b0;
`endif
    for (int c = 0; c < NCH; c++) d[c] = DRST;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_extlock", 32'(extlock), 32'd0);
    check_eq("rst_lock_cnt", 32'(lock_cnt), 32'd0);
    check_eq("rst_clk_out", 32'(clk_out), 32'd0);
    check_eq("rst_clk_en", 32'(clk_en), 32'd0);

    // Lock from reset with the reset ratio on both channels
    rst_n = 1'b1;
    since = 0;
    step(LOCK + 8);

    // ch1=3, ch0=4
    load(16'h0304);
    step(LOCK + 24);

    // Clamp: ratios 1 and 0 behave as 2
    load(16'h0100);
    step(LOCK + 8);

    // Relock while locked, then a second load at lock_cnt=30
    load(16'h0305);
    step(30);
    load(16'h0206);
    step(LOCK + 14);

    // Async reset between edges clears outputs without a clock edge
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_extlock", 32'(extlock), 32'd0);
    check_eq("arst_lock_cnt", 32'(lock_cnt), 32'd0);
    check_eq("arst_clk_out", 32'(clk_out), 32'd0);
    check_eq("arst_clk_en", 32'(clk_en), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    since = 0;
    for (int c = 0; c < NCH; c++) d[c] = DRST;
    step(LOCK + 6);

`ifdef PLL_STDBY_EN
    // Standby while locked, with a cfg_load latched during standby
    stdby = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        div_cfg  = 16'h0304;
        cfg_load = 1'b1;
        set_ratios(16'h0304);
      end
      since = 0;
      sb.push_back(model(0));
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      compare_head();
    end
    stdby = 1'b0;
    step(LOCK + 12);
`endif

    check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
